// File: rtl/zap_copro_pkg.sv
// Shared types and helpers for the coprocessor dispatch block.
package zap_copro_pkg;

    localparam int unsigned CP_FIELD_MSB = 11;
    localparam int unsigned CP_FIELD_LSB = 8;
    localparam int unsigned MAX_CP       = 16;
    localparam int unsigned CP_ID_W      = 4;
    localparam int unsigned LIST_W       = MAX_CP * CP_ID_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic                hit;
        logic [CP_ID_W-1:0]  idx;
    } cp_match_t;

    // Lowest populated slot whose CP number equals the instruction's CP field.
    function automatic cp_match_t cp_match(
        input logic [31:0]       word,
        input logic [LIST_W-1:0] list,
        input int unsigned       num_cp
    );
        cp_match_t          m;
        logic [CP_ID_W-1:0] field;
        m     = '0;
        field = word[CP_FIELD_MSB:CP_FIELD_LSB];
        for (int unsigned k = 0; k < MAX_CP; k++) begin
            if (!m.hit && (k < num_cp) && (list[k*CP_ID_W +: CP_ID_W] == field)) begin
                m.hit = 1'b1;
                m.idx = CP_ID_W'(k);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/zap_copro_regport_mux.sv
// Selects the granted coprocessor's register-file request; all zero when no grant.
module zap_copro_regport_mux #(
    parameter int unsigned NUM_CP = 2,
    parameter int unsigned RA_W   = 6,
    parameter int unsigned GW     = 1
) (
    input  logic [GW-1:0]          grant_idx,
    input  logic                   grant_valid,
    input  logic [NUM_CP-1:0]      cp_reg_en,
    input  logic [NUM_CP-1:0]      cp_reg_wr,
    input  logic [NUM_CP*RA_W-1:0] cp_reg_addr,
    input  logic [NUM_CP*32-1:0]   cp_reg_wdata,
    output logic                   reg_en,
    output logic                   reg_wr,
    output logic [RA_W-1:0]        reg_addr,
    output logic [31:0]            reg_wdata
);

    always_comb begin
        reg_en    = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        if (grant_valid) begin
            reg_en    = cp_reg_en[grant_idx];
            reg_wr    = cp_reg_wr[grant_idx];
            reg_addr  = cp_reg_addr[grant_idx*RA_W +: RA_W];
            reg_wdata = cp_reg_wdata[grant_idx*32 +: 32];
        end
    end

endmodule

// File: rtl/zap_copro_dispatch.sv
// Routes predecode coprocessor instructions to the matching attached unit and
// lends it the shared register-file port until it finishes, times out or is flushed.
module zap_copro_dispatch
    import zap_copro_pkg::*;
#(
    parameter int unsigned          NUM_CP     = 2,
    // slot 0 serves CP14, slot 1 serves CP15
    parameter logic [NUM_CP*4-1:0]  CP_ID_LIST = {4'd15, 4'd14},
    parameter int unsigned          TIMEOUT    = 256,
    parameter int unsigned          PHY_REGS   = 46,
    localparam int unsigned         RA_W       = $clog2(PHY_REGS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_copro_dav,
    input  logic [31:0]            i_copro_word,
    output logic                   o_copro_done,
    output logic                   o_copro_undef,
    output logic [NUM_CP-1:0]      o_cp_dav,
    output logic [31:0]            o_cp_word,
    input  logic [NUM_CP-1:0]      i_cp_done,
    input  logic [NUM_CP-1:0]      i_cp_reg_en,
    input  logic [NUM_CP-1:0]      i_cp_reg_wr,
    input  logic [NUM_CP*RA_W-1:0] i_cp_reg_addr,
    input  logic [NUM_CP*32-1:0]   i_cp_reg_wdata,
    output logic                   o_reg_en,
    output logic                   o_reg_wr,
    output logic [RA_W-1:0]        o_reg_addr,
    output logic [31:0]            o_reg_wdata,
    input  logic [31:0]            i_reg_rdata,
    output logic [31:0]            o_cp_reg_rdata
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_CP-1:0]   cp_dav_d;
    logic [31:0]         cp_word_d;
    logic                done_d, undef_d;
    cp_match_t           match;
    logic                grant_done;

    assign match      = cp_match(i_copro_word, LIST_W'(CP_ID_LIST), NUM_CP);
    assign grant_done = i_cp_done[grant_q];

    // Next state and next register values; flush beats done, done beats timeout.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        timer_d   = timer_q;
        cp_dav_d  = o_cp_dav;
        cp_word_d = o_cp_word;
        done_d    = o_copro_done;
        undef_d   = o_copro_undef;
        case (state_q)
            IDLE: begin
                if (i_copro_dav) begin
                    cp_word_d = i_copro_word;
                    timer_d   = '0;
                    if (match.hit) begin
                        state_d  = GRANT;
                        grant_d  = GW'(match.idx);
                        cp_dav_d = NUM_CP'(1) << match.idx;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        undef_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (timer_q != T_SAT) begin
                    timer_d = timer_q + TW'(1);
                end
                if (!i_copro_dav) begin
                    state_d  = IDLE;
                    cp_dav_d = '0;
                end else if (grant_done) begin
                    state_d  = DONE;
                    cp_dav_d = '0;
                    done_d   = 1'b1;
                    undef_d  = 1'b0;
                end else if (timer_q == T_LAST) begin
                    state_d  = DONE;
                    cp_dav_d = '0;
                    done_d   = 1'b1;
                    undef_d  = 1'b1;
                end
            end
            DONE: begin
                if (!i_copro_dav) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    undef_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                cp_dav_d = '0;
                done_d   = 1'b0;
                undef_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            timer_q       <= '0;
            o_cp_dav      <= '0;
            o_cp_word     <= '0;
            o_copro_done  <= 1'b0;
            o_copro_undef <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            timer_q       <= timer_d;
            o_cp_dav      <= cp_dav_d;
            o_cp_word     <= cp_word_d;
            o_copro_done  <= done_d;
            o_copro_undef <= undef_d;
        end
    end

    zap_copro_regport_mux #(
        .NUM_CP (NUM_CP),
        .RA_W   (RA_W),
        .GW     (GW)
    ) u_regport (
        .grant_idx    (grant_q),
        .grant_valid  (state_q == GRANT),
        .cp_reg_en    (i_cp_reg_en),
        .cp_reg_wr    (i_cp_reg_wr),
        .cp_reg_addr  (i_cp_reg_addr),
        .cp_reg_wdata (i_cp_reg_wdata),
        .reg_en       (o_reg_en),
        .reg_wr       (o_reg_wr),
        .reg_addr     (o_reg_addr),
        .reg_wdata    (o_reg_wdata)
    );

    assign o_cp_reg_rdata = i_reg_rdata;

endmodule

// File: tb/tb_zap_copro_dispatch.sv
// Self-checking bench for zap_copro_dispatch: vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_zap_copro_dispatch;

    localparam int TO   = 8;
    localparam int RA_W = 6;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_copro_dav;
    logic [31:0]   i_copro_word;
    logic          o_copro_done;
    logic          o_copro_undef;
    logic [1:0]    o_cp_dav;
    logic [31:0]   o_cp_word;
    logic [1:0]    i_cp_done;
    logic [1:0]    i_cp_reg_en;
    logic [1:0]    i_cp_reg_wr;
    logic [2*RA_W-1:0] i_cp_reg_addr;
    logic [63:0]   i_cp_reg_wdata;
    logic          o_reg_en;
    logic          o_reg_wr;
    logic [RA_W-1:0] o_reg_addr;
    logic [31:0]   o_reg_wdata;
    logic [31:0]   i_reg_rdata;
    logic [31:0]   o_cp_reg_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    zap_copro_dispatch #(
        .NUM_CP     (2),
        .CP_ID_LIST ({4'd15, 4'd14}),
        .TIMEOUT    (TO),
        .PHY_REGS   (46)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_copro_dav    (i_copro_dav),
        .i_copro_word   (i_copro_word),
        .o_copro_done   (o_copro_done),
        .o_copro_undef  (o_copro_undef),
        .o_cp_dav       (o_cp_dav),
        .o_cp_word      (o_cp_word),
        .i_cp_done      (i_cp_done),
        .i_cp_reg_en    (i_cp_reg_en),
        .i_cp_reg_wr    (i_cp_reg_wr),
        .i_cp_reg_addr  (i_cp_reg_addr),
        .i_cp_reg_wdata (i_cp_reg_wdata),
        .o_reg_en       (o_reg_en),
        .o_reg_wr       (o_reg_wr),
        .o_reg_addr     (o_reg_addr),
        .o_reg_wdata    (o_reg_wdata),
        .i_reg_rdata    (i_reg_rdata),
        .o_cp_reg_rdata (o_cp_reg_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] field;
        int         delay;     // GRANT cycle index where the unit answers, -1 never
        int         flush_at;  // GRANT cycle index where dav drops, -1 never
        int         stall;     // extra cycles dav stays high after done
        logic [1:0] exp_dav;
        logic       exp_undef;
        int         exp_end;   // GRANT cycle index whose closing edge raises done
    } tv_t;

    tv_t tv[10];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Expected outcome from the dispatch rules: lowest slot with matching CP number,
    // answer in time clears undef, otherwise timeout after TO grant cycles.
    function automatic void model(input logic [3:0] field, input int delay,
                                  output logic [1:0] dav, output logic undef, output int endc);
        logic [3:0] ids[2];
        ids[0] = 4'd14;
        ids[1] = 4'd15;
        dav = 2'b00;
        for (int k = 0; k < 2; k++)
            if (dav == 2'b00 && ids[k] == field) dav = 2'b01 << k;
        if (dav == 2'b00) begin
            undef = 1'b1; endc = 0;
        end else if (delay >= 0 && delay < TO) begin
            undef = 1'b0; endc = delay;
        end else begin
            undef = 1'b1; endc = TO - 1;
        end
    endfunction

    task automatic run_txn(input logic [3:0] field, input int delay, input int flush_at,
                           input int stall, input logic [1:0] exp_dav, input logic exp_undef,
                           input int exp_end, input string tag);
        logic [31:0] w;
        bit ended   = 1'b0;
        bit flushed = 1'b0;
        w = $urandom;
        w[11:8] = field;
        i_copro_word = w;
        i_copro_dav  = 1'b1;
        i_cp_done    = 2'b00;
        tick();
        chk({tag, ".cp_dav"}, 32'(o_cp_dav), 32'(exp_dav));
        chk({tag, ".cp_word"}, o_cp_word, w);
        if (exp_dav == 2'b00) begin
            chk({tag, ".nomatch_done"}, 32'(o_copro_done), 32'd1);
            chk({tag, ".nomatch_undef"}, 32'(o_copro_undef), 32'd1);
            ended = 1'b1;
        end
        for (int g = 0; g <= TO && !ended; g++) begin
            if (g == flush_at) begin
                i_copro_dav = 1'b0;
                i_cp_done   = exp_dav;
                tick();
                i_cp_done = 2'b00;
                chk({tag, ".flush_cp_dav"}, 32'(o_cp_dav), 32'd0);
                chk({tag, ".flush_done"}, 32'(o_copro_done), 32'd0);
                tick();
                chk({tag, ".flush_done2"}, 32'(o_copro_done), 32'd0);
                flushed = 1'b1;
                ended   = 1'b1;
            end else begin
                i_cp_done = (g == delay) ? exp_dav : ((g == 0) ? ~exp_dav : 2'b00);
                tick();
                i_cp_done = 2'b00;
                if (g == exp_end) begin
                    chk({tag, ".done"}, 32'(o_copro_done), 32'd1);
                    chk({tag, ".undef"}, 32'(o_copro_undef), 32'(exp_undef));
                    chk({tag, ".dav_clr"}, 32'(o_cp_dav), 32'd0);
                    ended = 1'b1;
                end else begin
                    chk({tag, ".busy_done"}, 32'(o_copro_done), 32'd0);
                    chk({tag, ".busy_dav"}, 32'(o_cp_dav), 32'(exp_dav));
                end
            end
        end
        if (!ended) chk({tag, ".ended"}, 32'd0, 32'd1);
        if (!flushed) begin
            for (int s = 0; s < stall; s++) begin
                i_cp_done = (s == 0) ? exp_dav : 2'b00;
                tick();
                i_cp_done = 2'b00;
                chk({tag, ".hold_done"}, 32'(o_copro_done), 32'd1);
                chk({tag, ".hold_undef"}, 32'(o_copro_undef), 32'(exp_undef));
                chk({tag, ".hold_dav"}, 32'(o_cp_dav), 32'd0);
            end
            i_copro_dav = 1'b0;
            tick();
            chk({tag, ".release_done"}, 32'(o_copro_done), 32'd0);
            chk({tag, ".release_undef"}, 32'(o_copro_undef), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] m_dav;
        logic       m_undef;
        int         m_end;
        logic [3:0] f;
        int         d, fl, st;

        tv[0] = '{4'hF,  5, -1, 1, 2'b10, 1'b0, 5};
        tv[1] = '{4'h5, -1, -1, 2, 2'b00, 1'b1, 0};
        tv[2] = '{4'hE, -1, -1, 2, 2'b01, 1'b1, 7};
        tv[3] = '{4'hE,  0, -1, 0, 2'b01, 1'b0, 0};
        tv[4] = '{4'hF,  7, -1, 1, 2'b10, 1'b0, 7};
        tv[5] = '{4'hF,  9, -1, 1, 2'b10, 1'b1, 7};
        tv[6] = '{4'hE,  3,  2, 0, 2'b01, 1'b0, 3};
        tv[7] = '{4'hF,  4,  4, 0, 2'b10, 1'b0, 4};
        tv[8] = '{4'hF,  2, -1, 4, 2'b10, 1'b0, 2};
        tv[9] = '{4'h0, -1, -1, 0, 2'b00, 1'b1, 0};

        i_reset        = 1'b1;
        i_copro_dav    = 1'b0;
        i_copro_word   = 32'h0;
        i_cp_done      = 2'b00;
        i_cp_reg_en    = 2'b00;
        i_cp_reg_wr    = 2'b00;
        i_cp_reg_addr  = '0;
        i_cp_reg_wdata = '0;
        i_reg_rdata    = 32'h0;
        tick();
        tick();
        i_reset = 1'b0;
        chk("rst.cp_dav", 32'(o_cp_dav), 32'd0);
        chk("rst.cp_word", o_cp_word, 32'd0);
        chk("rst.done", 32'(o_copro_done), 32'd0);
        chk("rst.undef", 32'(o_copro_undef), 32'd0);

        for (int i = 0; i < 10; i++)
            run_txn(tv[i].field, tv[i].delay, tv[i].flush_at, tv[i].stall,
                    tv[i].exp_dav, tv[i].exp_undef, tv[i].exp_end, $sformatf("tv%0d", i));

        // Register-file port: only the granted slot reaches the shared port.
        i_cp_reg_en    = 2'b11;
        i_cp_reg_wr    = 2'b01;
        i_cp_reg_addr  = {6'd3, 6'd9};
        i_cp_reg_wdata = {32'h1111_2222, 32'hAAAA_5555};
        #1;
        chk("rp.idle_en", 32'(o_reg_en), 32'd0);
        i_copro_word = 32'hEE10_0F10;
        i_copro_dav  = 1'b1;
        tick();
        chk("rp.cp_dav", 32'(o_cp_dav), 32'd2);
        chk("rp.en", 32'(o_reg_en), 32'd1);
        chk("rp.wr", 32'(o_reg_wr), 32'd0);
        chk("rp.addr", 32'(o_reg_addr), 32'd3);
        chk("rp.wdata", o_reg_wdata, 32'h1111_2222);
        tick();
        i_reg_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rp.rdata", o_cp_reg_rdata, 32'hDEAD_BEEF);
        i_cp_reg_en = 2'b01;
        #1;
        chk("rp.slot0_dropped", 32'(o_reg_en), 32'd0);
        i_cp_done = 2'b10;
        tick();
        i_cp_done = 2'b00;
        chk("rp.done", 32'(o_copro_done), 32'd1);
        chk("rp.done_en", 32'(o_reg_en), 32'd0);
        i_copro_dav = 1'b0;
        tick();

        // Reset while a unit holds the grant.
        i_copro_word = 32'h0000_0E00;
        i_copro_dav  = 1'b1;
        tick();
        tick();
        chk("mrst.pre_dav", 32'(o_cp_dav), 32'd1);
        i_reset = 1'b1;
        tick();
        chk("mrst.cp_dav", 32'(o_cp_dav), 32'd0);
        chk("mrst.cp_word", o_cp_word, 32'd0);
        chk("mrst.done", 32'(o_copro_done), 32'd0);
        chk("mrst.undef", 32'(o_copro_undef), 32'd0);
        chk("mrst.reg_en", 32'(o_reg_en), 32'd0);
        i_copro_dav = 1'b0;
        i_reset     = 1'b0;
        i_cp_reg_en = 2'b00;
        tick();
        chk("mrst.idle_done", 32'(o_copro_done), 32'd0);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       f = 4'hE;
                1:       f = 4'hF;
                default: f = 4'($urandom_range(0, 15));
            endcase
            d  = $urandom_range(0, 11);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
            st = $urandom_range(0, 3);
            model(f, d, m_dav, m_undef, m_end);
            run_txn(f, d, fl, st, m_dav, m_undef, m_end, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
